// File: rtl/x_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x_mem_pkg
// Description : Shared types and constants for the RV32I memory-side bridge:
//               region decode, bridge state encoding and the request record.
// Revision    : 1.0 - initial release
// ============================================================================
package x_mem_pkg;

    // Address regions selected by the top nibble of the byte address.
    typedef enum logic [1:0] {
        REG_SRAM     = 2'd0,
        REG_PERIPH   = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_t;

    // Bridge state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM     = 2'd1,
        ST_PER_REQ = 2'd2,
        ST_RESP    = 2'd3
    } bridge_sm_t;

    localparam logic [3:0]  REGION_SRAM   = 4'h0;
    localparam logic [3:0]  REGION_PERIPH = 4'h4;
    localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;

    // Captured core request, held for the whole transaction.
    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    // Map the top address nibble to a region.
    function automatic region_t decode_region(input logic [3:0] nibble);
        region_t region;
        case (nibble)
            REGION_SRAM:   region = REG_SRAM;
            REGION_PERIPH: region = REG_PERIPH;
            default:       region = REG_UNMAPPED;
        endcase
        return region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_sram_sp.sv
`default_nettype none
// ============================================================================
// Module      : x_sram_sp
// Description : Single-port synchronous SRAM, 32-bit words, registered read
//               data.
// Revision    : 1.0 - initial release
// ============================================================================
module x_sram_sp #(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Write port and registered read port; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/x_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : x_mem_bridge
// Description : Memory-side target for the core request bus. Decodes each
//               request to SRAM, peripheral port or unmapped space, one
//               request in flight, peripheral accesses bounded by a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module x_mem_bridge
    import x_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter     INIT_FILE = "",
    parameter int PER_AW    = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_valid,
    input  logic              i_rnw,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    output logic              o_accept,
    output logic [31:0]       o_data,
    output logic              o_per_valid,
    output logic              o_per_rnw,
    output logic [PER_AW-1:0] o_per_addr,
    output logic [31:0]       o_per_data,
    input  logic              i_per_ready,
    input  logic [31:0]       i_per_data,
    output logic              o_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    bridge_sm_t        r_state;
    bridge_sm_t        w_next;
    req_t              r_req;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_from_sram;
    region_t           w_region;
    logic              w_timeout;
    logic              w_sram_we;
    logic              w_sram_re;
    logic [IDX_W-1:0]  w_sram_idx;
    logic [31:0]       w_sram_rdata;
    logic              w_unused_addr;

    assign w_region   = decode_region(i_addr[31:28]);
    assign w_timeout  = (r_cnt == C_CNT_LAST);
    // Upper region-0 bits are dropped so the SRAM aliases across the region.
    assign w_sram_idx = r_req.addr[2 +: IDX_W];
    assign w_sram_we  = (r_state == ST_MEM) && !r_req.rnw;
    assign w_sram_re  = (r_state == ST_MEM) &&  r_req.rnw;
    // Only some captured address bits feed the datapath, depending on sizing.
    assign w_unused_addr = ^r_req.addr;

    x_sram_sp #(
        .DEPTH     (MEM_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .i_clk   (i_clk),
        .i_we    (w_sram_we),
        .i_re    (w_sram_re),
        .i_idx   (w_sram_idx),
        .i_wdata (r_req.data),
        .o_rdata (w_sram_rdata)
    );

    // State register; asynchronous reset abandons any transaction in flight.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    case (w_region)
                        REG_SRAM:   w_next = ST_MEM;
                        REG_PERIPH: w_next = ST_PER_REQ;
                        default:    w_next = ST_RESP;
                    endcase
                end
            end
            ST_MEM:     w_next = ST_RESP;
            ST_PER_REQ: begin
                if (i_per_ready || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Request capture, timeout counter and response data/error registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_req       <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_from_sram <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_req.rnw   <= i_rnw;
                        r_req.addr  <= i_addr;
                        r_req.data  <= i_data;
                        r_cnt       <= '0;
                        r_rdata     <= '0;
                        r_from_sram <= 1'b0;
                        r_err       <= (w_region == REG_UNMAPPED);
                    end
                end
                ST_MEM: begin
                    // Read data comes from the SRAM output register in RESP.
                    r_from_sram <= r_req.rnw;
                    r_rdata     <= '0;
                end
                ST_PER_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (i_per_ready) begin
                        r_rdata <= r_req.rnw ? i_per_data : 32'h0;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_err       <= 1'b0;
                    r_from_sram <= 1'b0;
                end
            endcase
        end
    end

    // Bus outputs; everything reads zero outside its qualifying state.
    always_comb begin
        o_accept    = 1'b0;
        o_data      = 32'h0;
        o_err       = 1'b0;
        o_per_valid = 1'b0;
        o_per_rnw   = 1'b0;
        o_per_addr  = '0;
        o_per_data  = 32'h0;
        case (r_state)
            ST_RESP: begin
                o_accept = 1'b1;
                o_data   = r_from_sram ? w_sram_rdata : r_rdata;
                o_err    = r_err;
            end
            ST_PER_REQ: begin
                o_per_valid = 1'b1;
                o_per_rnw   = r_req.rnw;
                o_per_addr  = r_req.addr[PER_AW+1:2];
                o_per_data  = r_req.data;
            end
            default: begin
                o_accept = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_x_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_mem_bridge
// Description : Self-checking bench for x_mem_bridge with a word-array memory
//               model, latency expectations and a scripted peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_mem_bridge;

    localparam int MEM_DEPTH = 64;
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int PER_AW    = 8;
    localparam int TIMEOUT   = 8;

    logic              clk;
    logic              nrst;
    logic              valid;
    logic              rnw;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              accept;
    logic [31:0]       rdata;
    logic              per_valid;
    logic              per_rnw;
    logic [PER_AW-1:0] per_addr;
    logic [31:0]       per_wdata;
    logic              per_ready;
    logic [31:0]       per_rdata;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [MEM_DEPTH];

    x_mem_bridge #(
        .MEM_DEPTH (MEM_DEPTH),
        .INIT_FILE (""),
        .PER_AW    (PER_AW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_valid     (valid),
        .i_rnw       (rnw),
        .i_addr      (addr),
        .i_data      (wdata),
        .o_accept    (accept),
        .o_data      (rdata),
        .o_per_valid (per_valid),
        .o_per_rnw   (per_rnw),
        .o_per_addr  (per_addr),
        .o_per_data  (per_wdata),
        .i_per_ready (per_ready),
        .i_per_data  (per_rdata),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus transaction; expectations come from the region rules and the
    // word-array memory model, then the DUT's response and latency are checked.
    task automatic req(input logic t_rnw, input logic [31:0] t_addr, input logic [31:0] t_data,
                       input int delay, input logic [31:0] pdata);
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
        int          idx;
        int          lat;
        int          pcnt;
        logic        got;
        logic        seen_per;
        logic        quiet_ok;
        logic [31:0] a_data;
        logic        a_err;

        idx = int'(t_addr[2 +: IDX_W]);
        case (t_addr[31:28])
            4'h0: begin
                e_lat = 2;
                e_err = 1'b0;
                if (t_rnw) begin
                    e_data = m_mem[idx];
                end else begin
                    e_data     = 32'h0;
                    m_mem[idx] = t_data;
                end
            end
            4'h4: begin
                if (delay < TIMEOUT) begin
                    e_lat  = 2 + delay;
                    e_err  = 1'b0;
                    e_data = t_rnw ? pdata : 32'h0;
                end else begin
                    e_lat  = 1 + TIMEOUT;
                    e_err  = 1'b1;
                    e_data = 32'hDEAD_BEEF;
                end
            end
            default: begin
                e_lat  = 1;
                e_err  = 1'b1;
                e_data = 32'h0;
            end
        endcase

        @(negedge clk);
        valid     = 1'b1;
        rnw       = t_rnw;
        addr      = t_addr;
        wdata     = t_data;
        per_rdata = pdata;
        per_ready = 1'b0;
        lat       = 0;
        pcnt      = 0;
        got       = 1'b0;
        seen_per  = 1'b0;
        quiet_ok  = 1'b1;
        a_data    = 32'h0;
        a_err     = 1'b0;

        for (int c = 0; c < TIMEOUT + 8 && !got; c++) begin
            if (per_valid) begin
                if (!seen_per) begin
                    chk($sformatf("per_addr@%08h", t_addr), 32'(per_addr), 32'(t_addr[PER_AW+1:2]));
                    chk($sformatf("per_rnw@%08h", t_addr), 32'(per_rnw), 32'(t_rnw));
                    chk($sformatf("per_data@%08h", t_addr), per_wdata, t_data);
                    seen_per = 1'b1;
                end
                per_ready = (pcnt == delay);
                pcnt++;
            end else begin
                per_ready = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (accept) begin
                got    = 1'b1;
                a_data = rdata;
                a_err  = err;
            end else if (rdata !== 32'h0 || err !== 1'b0) begin
                quiet_ok = 1'b0;
            end
        end
        valid     = 1'b0;
        per_ready = 1'b0;

        chk($sformatf("accepted@%08h", t_addr), 32'(got), 32'd1);
        chk($sformatf("latency@%08h", t_addr), 32'(lat), 32'(e_lat));
        chk($sformatf("data@%08h", t_addr), a_data, e_data);
        chk($sformatf("err@%08h", t_addr), 32'(a_err), 32'(e_err));
        chk($sformatf("quiet@%08h", t_addr), 32'(quiet_ok), 32'd1);
        chk($sformatf("per_seen@%08h", t_addr), 32'(seen_per), 32'(t_addr[31:28] == 4'h4));
    endtask

    initial begin
        logic [3:0] nib;
        int         sel;
        logic       pre_ok;

        nrst      = 1'b0;
        valid     = 1'b0;
        rnw       = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        per_ready = 1'b0;
        per_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_accept", 32'(accept), 32'd0);
        chk("rst_data", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_per_valid", 32'(per_valid), 32'd0);
        chk("rst_per_bus", {23'h0, per_rnw, per_addr} | per_wdata, 32'h0);
        nrst = 1'b1;

        // Preload: boot word at 0, random fill elsewhere
        req(1'b0, 32'h0000_0000, 32'h0000_0013, 0, 32'h0);
        for (int i = 1; i < MEM_DEPTH; i++) begin
            req(1'b0, 32'(i * 4), $urandom, 0, 32'h0);
        end

        // Directed cases
        req(1'b1, 32'h0000_0000, 32'h0, 0, 32'h0);
        req(1'b0, 32'h0000_0010, 32'hCAFE_F00D, 0, 32'h0);
        req(1'b1, 32'h0000_0012, 32'h0, 0, 32'h0);
        req(1'b1, 32'h0000_0010 + 32'(MEM_DEPTH * 4), 32'h0, 0, 32'h0);
        req(1'b1, 32'h4000_0008, 32'h0, 3, 32'h0000_0055);
        req(1'b1, 32'h4000_0020, 32'h0, 1000, 32'h1234_5678);
        req(1'b1, 32'h4000_0024, 32'h0, TIMEOUT - 1, 32'hA5A5_0001);
        req(1'b0, 32'h4000_00FC, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF);
        req(1'b1, 32'h8000_0000, 32'h0, 0, 32'h0);
        req(1'b0, 32'h8000_0000, 32'h7777_7777, 0, 32'h0);
        req(1'b1, 32'h0000_0000, 32'h0, 0, 32'h0);
        req(1'b1, 32'h0000_0010, 32'h0, 0, 32'h0);

        // Randomized traffic across all regions
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel <= 1) begin
                nib = 4'h0;
            end else if (sel == 2) begin
                nib = 4'h4;
            end else begin
                nib = 4'($urandom_range(1, 15));
                if (nib == 4'h4) nib = 4'hF;
            end
            req(1'($urandom), {nib, 28'($urandom)}, $urandom,
                int'($urandom_range(0, TIMEOUT + 1)), $urandom);
        end

        // Reset in the middle of a peripheral access
        @(negedge clk);
        valid     = 1'b1;
        rnw       = 1'b1;
        addr      = 32'h4000_0010;
        per_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_per_valid", 32'(per_valid), 32'd1);
        #2;
        nrst  = 1'b0;
        valid = 1'b0;
        #1;
        chk("mid_rst_per_valid", 32'(per_valid), 32'd0);
        chk("mid_rst_accept", 32'(accept), 32'd0);
        pre_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (accept !== 1'b0 || per_valid !== 1'b0) pre_ok = 1'b0;
        end
        nrst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (accept !== 1'b0 || per_valid !== 1'b0) pre_ok = 1'b0;
        end
        chk("post_rst_quiet", 32'(pre_ok), 32'd1);
        req(1'b1, 32'h0000_0000, 32'h0, 0, 32'h0);
        req(1'b1, 32'h4000_0010, 32'h0, 2, 32'hFEED_0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
